// File: rtl/me_pkg.sv
// Shared constants and state type for the motion-estimation sequencer.
package me_pkg;

   localparam int unsigned NPE       = 16;
   localparam int unsigned WIN_W     = 32;
   localparam int unsigned RUN_LEN   = 4096;
   localparam int unsigned DRAIN_LEN = 16;
   localparam int unsigned CNT_W     = 13;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } me_state_e;

endpackage

// File: rtl/me_addr_gen.sv
// Combinational decode of the search counter into memory addresses and the
// per-PE S1/S2 select vector. Gating by FSM state is left to the caller.
module me_addr_gen
   import me_pkg::*;
(
   input  logic [11:0]    count,
   output logic [7:0]     addr_r,
   output logic [9:0]     addr_s1,
   output logic [9:0]     addr_s2,
   output logic [NPE-1:0] mux
);

   logic [4:0] row;

   // m + r selects the window row; the sum never exceeds 30, so 5 bits suffice.
   assign row     = {1'b0, count[11:8]} + {1'b0, count[7:4]};
   assign addr_r  = count[7:0];
   // row*32 + c: bit 4 is always clear, so adding 16 just sets it.
   assign addr_s1 = {row, 1'b0, count[3:0]};
   assign addr_s2 = {row, 1'b1, count[3:0]};

   // PE k reads S1 once the column index has reached k.
   always_comb begin
      mux = '0;
      for (int k = 0; k < NPE; k++) begin
         mux[k] = (count[3:0] >= 4'(k));
      end
   end

endmodule

// File: rtl/me_control.sv
// Sequencer for the 16-PE motion-estimation array: runs a 4096-cycle search
// followed by a 16-cycle drain, generating memory addresses, PE controls and
// the completed-candidate flags. All outputs decode from registered state.
module me_control #(
   parameter int unsigned NPE = 16
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic           memEn,
   output logic [7:0]     AddressR,
   output logic [9:0]     AddressS1,
   output logic [9:0]     AddressS2,
   output logic [NPE-1:0] s1s2mux,
   output logic [NPE-1:0] newDist,
   output logic [NPE-1:0] PEready,
   output logic [3:0]     vecX,
   output logic [3:0]     vecY
);

   import me_pkg::*;

   localparam logic [CNT_W-1:0] RunLast   = CNT_W'(RUN_LEN - 1);
   localparam logic [CNT_W-1:0] DrainLast = CNT_W'(RUN_LEN + DRAIN_LEN - 1);
   localparam logic [CNT_W-1:0] FirstDone = CNT_W'(256);

   me_state_e        state_q;
   logic [CNT_W-1:0] count_q;
   logic             done_q;

   logic             active;
   logic [7:0]       gen_r;
   logic [9:0]       gen_s1;
   logic [9:0]       gen_s2;
   logic [NPE-1:0]   gen_mux;
   logic [NPE-1:0]   new_dist;
   logic [NPE-1:0]   pe_ready;
   logic [4:0]       vec_y_full;

   // FSM and counter; done is registered so it lands in the first IDLE cycle.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               count_q <= '0;
               if (start) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               count_q <= count_q + 1'b1;
               if (count_q == RunLast) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (count_q == DrainLast) begin
                  state_q <= IDLE;
                  count_q <= '0;
                  done_q  <= 1'b1;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               count_q <= '0;
            end
         endcase
      end
   end

   me_addr_gen u_addr_gen (
      .count   (count_q[11:0]),
      .addr_r  (gen_r),
      .addr_s1 (gen_s1),
      .addr_s2 (gen_s2),
      .mux     (gen_mux)
   );

   assign active = (state_q != IDLE);
   assign busy   = active;
   assign done   = done_q;
   assign memEn  = (state_q == RUN);

   // Addresses are held at zero while idle so reset leaves every output low.
   assign AddressR  = active ? gen_r  : '0;
   assign AddressS1 = active ? gen_s1 : '0;
   assign AddressS2 = active ? gen_s2 : '0;
   assign s1s2mux   = memEn  ? gen_mux : '0;

   // PE k starts a new accumulation when the low count byte equals k.
   always_comb begin
      new_dist = '0;
      if (active) begin
         for (int k = 0; k < NPE; k++) begin
            new_dist[k] = (count_q[7:0] == 8'(k));
         end
      end
   end

   // The first 256 cycles have no finished candidate to report.
   assign pe_ready   = (count_q >= FirstDone) ? new_dist : '0;
   assign newDist    = new_dist;
   assign PEready    = pe_ready;
   assign vec_y_full = count_q[12:8] - 5'd1;

   // pe_ready is non-zero only when count[7:4] is zero, so count[3:0] is the PE index.
   always_comb begin
      vecX = '0;
      vecY = '0;
      if (pe_ready != '0) begin
         vecX = count_q[3:0];
         vecY = vec_y_full[3:0];
      end
   end

endmodule

// File: doc/me_control.md
# me_control

Sequencer that drives the 16-PE motion-estimation array. For one 16×16 reference block searched over a 32×32 window, it generates the R/S1/S2 memory addresses and the per-PE `s1s2mux` and `newDist` control vectors that PEtotal consumes. It also flags which PE holds a finished distortion and the candidate motion vector that value belongs to. It sits between the top-level start/done handshake and the PE array, memories and comparator.

## Interface
- `NPE`, 16: number of PEs and block width. Only 16 is supported.
- `clock` in 1: rising-edge clock.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a search. Ignored unless idle.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse when the search completes.
- `memEn` out 1: memory read enable. High only in RUN.
- `AddressR` out 8: reference-block address.
- `AddressS1` out 10: search-window address, upper half.
- `AddressS2` out 10: search-window address, lower half (S1 + 16).
- `s1s2mux` out 16: per-PE select. Bit k = 1 selects S1.
- `newDist` out 16: per-PE "start new accumulation" control.
- `PEready` out 16: one-hot. Bit k marks that PE k's accumulator holds a completed distortion.
- `vecX` out 4: horizontal offset of the completed candidate.
- `vecY` out 4: vertical offset of the completed candidate.

## Operation
- FSM states: IDLE, RUN, DRAIN. Counter `count` is 13 bits.
- IDLE:
  - `count` = 0.
  - On `start` = 1, go to RUN with `count` = 0.
- RUN:
  - `count` increments every cycle.
  - After `count` = 4095, go to DRAIN with `count` = 4096.
- DRAIN:
  - Covers `count` 4096..4111.
  - After 4111, return to IDLE and pulse `done` on that transition.
- Field decode of `count`: m = `count[11:8]`, r = `count[7:4]`, c = `count[3:0]`.
- Address generation (the m + r sum is 5 bits, no overflow):
  - `AddressR` = `count[7:0]`.
  - `AddressS1` = (m + r)·32 + c.
  - `AddressS2` = `AddressS1` + 16.
- `s1s2mux[k]` = (c ≥ k) in RUN; 0 in DRAIN and IDLE.
- `newDist[k]` = (`count[7:0]` == k) in RUN and DRAIN; 0 in IDLE.
- `PEready[k]` = `newDist[k]` AND (`count` ≥ 256). It is at most one-hot.
- Completed-candidate vector:
  - `vecX` = index of the set `PEready` bit.
  - `vecY` = `count[12:8]` − 1, truncated to 4 bits.
  - Both are 0 when `PEready` = 0.
- `start` while `busy` is ignored, with no restart and no queuing.
- `resetn` low at any time, including mid-RUN or mid-DRAIN:
  - Immediately forces IDLE and `count` = 0.
  - Drives all outputs to 0; no `done` pulse.

## Timing
- All outputs are decoded from registered state and `count` (Moore), so there is no combinational path from `start`.
- `start` sampled at edge E0 puts `count` = 0 on the outputs in the cycle after E0.
- Busy duration:
  - `busy` is high for exactly 4112 cycles.
  - `done` is high in the first IDLE cycle and `busy` is low in that same cycle.
- Throughput: a new `start` is accepted in the cycle `done` is high. Back-to-back searches therefore have 1 idle cycle between them.
- Memory read latency is the consumer's concern; this block applies no compensation.

## Structure
- Shared package `me_pkg` holds:
  - `NPE` = 16, `WIN_W` = 32, `RUN_LEN` = 4096, `DRAIN_LEN` = 16.
  - State enum {IDLE, RUN, DRAIN}.
- One sub-module: `me_addr_gen`, a purely combinational decode from `count` to `AddressR`/`AddressS1`/`AddressS2`/`s1s2mux`. The FSM, counter and `PEready`/vector logic stay in `me_control`.

## Test plan
- Reset and start:
  - Stimulus: hold `resetn` low, release, pulse `start`.
  - Required: all outputs 0 during reset.
  - Required: `busy` rises in the next cycle and `done` pulses exactly 4112 cycles later.
- Address decode:
  - Stimulus: at `count` = 0x123.
  - Required: `AddressR` = 35, `AddressS1` = 99, `AddressS2` = 115, `s1s2mux` = 16'h000F, `newDist` = 0, `memEn` = 1.
- Ready flags in RUN:
  - At `count` = 0x005: `newDist` = 16'h0020 and `PEready` = 0.
  - At `count` = 0x100: `PEready` = 16'h0001, `vecX` = 0, `vecY` = 0.
- Drain phase:
  - At `count` = 4111: `PEready` = 16'h8000, `vecX` = 15, `vecY` = 15, `s1s2mux` = 0, `memEn` = 0.
  - Required: `done` occurs in the following cycle.
- Start while busy and back-to-back:
  - Stimulus: pulse `start` at `count` = 2000.
  - Required: no effect, and completion timing is unchanged.
  - Stimulus: pulse `start` in the `done` cycle.
  - Required: a new RUN begins with `count` = 0 in the next cycle.
- Reset mid-operation:
  - Stimulus: assert `resetn` low at `count` = 1500, asynchronously between edges.
  - Required: outputs go to 0 immediately, with no `done` pulse.
  - Required: the next `start` yields a full 4112-cycle search.
